// File: rtl/flag_mac_loader.sv
`default_nettype none
// ============================================================================
//  Module   : flag_mac_loader
//  Purpose  : Host-side writer for the flagged MAC address used by the
//             sniffer's MAC matching stage. The host writes a 48-bit address
//             into staging registers through 32-bit register writes. The
//             staged value is copied to the live flagged_mac output only at a
//             frame boundary, so an in-progress comparison never sees a
//             half-updated address. Each commit raises commit_pulse for one
//             cycle; the matcher uses it as its synchronous clear.
//
//  Ports    : clk            - system clock, rising edge
//             n_rst          - asynchronous active-low reset
//             address[1:0]   - 0 MAC_LO, 1 MAC_HI, 2 CTRL, 3 STATUS
//             write          - write strobe (has priority over read)
//             writedata[31:0]- write data
//             read           - read strobe
//             readdata[31:0] - registered read data, holds when read=0
//             frame_idle     - no frame in progress on the data path
//             flagged_mac    - live address {MAC_HI[15:0], MAC_LO}
//             mac_valid      - CTRL.enable AND a commit has happened
//             update_pending - a staged address is waiting for a commit
//             commit_pulse   - one-cycle pulse after each commit
//
//  Options  : MAC_READBACK_EN - when defined, reads of MAC_LO / MAC_HI return
//             the staging registers; otherwise those reads return 0.
//
//  Revision : 1.0 - initial release
// ============================================================================
module flag_mac_loader (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        frame_idle,
  output logic [47:0] flagged_mac,
  output logic        mac_valid,
  output logic        update_pending,
  output logic        commit_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_LO     = 2'd0;
  localparam logic [1:0] ADDR_HI     = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  state_t      state_q,          state_d;
  logic [31:0] stage_lo_q,       stage_lo_d;
  logic [15:0] stage_hi_q,       stage_hi_d;
  logic        enable_q,         enable_d;
  logic        loaded_q,         loaded_d;
  logic [7:0]  commit_count_q,   commit_count_d;
  logic [47:0] flagged_mac_q,    flagged_mac_d;
  logic        mac_valid_q,      mac_valid_d;
  logic        update_pending_q, update_pending_d;
  logic        commit_pulse_q,   commit_pulse_d;
  logic [31:0] readdata_q,       readdata_d;

  logic        stage_wr;
  logic        hi_wr;
  logic        ctrl_wr;
  logic        abort;
  logic [31:0] rd_mux;

  always_comb begin
    // Any write to MAC_LO or MAC_HI blocks a commit in that cycle so the
    // live address is never built from a half-written pair.
    stage_wr = write && !address[1];
    hi_wr    = write && (address == ADDR_HI);
    ctrl_wr  = write && (address == ADDR_CTRL);
    abort    = ctrl_wr && writedata[1];

    state_d        = state_q;
    stage_lo_d     = stage_lo_q;
    stage_hi_d     = stage_hi_q;
    enable_d       = enable_q;
    loaded_d       = loaded_q;
    commit_count_d = commit_count_q;
    flagged_mac_d  = flagged_mac_q;

    if (write && (address == ADDR_LO)) stage_lo_d = writedata;
    if (hi_wr)                         stage_hi_d = writedata[15:0];
    if (ctrl_wr)                       enable_d   = writedata[0];

    case (state_q)
      ST_IDLE: begin
        if (hi_wr) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        // Abort wins over a commit that would otherwise happen this edge.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (frame_idle && !stage_wr) begin
          state_d        = ST_COMMIT;
          flagged_mac_d  = {stage_hi_q, stage_lo_q};
          loaded_d       = 1'b1;
          commit_count_d = commit_count_q + 8'd1;
        end
      end
      ST_COMMIT: begin
        state_d = hi_wr ? ST_ARMED : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered versions of the next-state view.
    update_pending_d = (state_d == ST_ARMED);
    commit_pulse_d   = (state_d == ST_COMMIT);
    mac_valid_d      = enable_d && loaded_d;

    rd_mux = 32'h0;
    case (address)
`ifdef MAC_READBACK_EN
      ADDR_LO:     rd_mux = stage_lo_q;
      ADDR_HI:     rd_mux = {16'h0, stage_hi_q};
`endif
      ADDR_CTRL:   rd_mux = {31'h0, enable_q};
      ADDR_STATUS: rd_mux = {16'h0, commit_count_q, 6'h0, mac_valid_q, update_pending_q};
      default:     rd_mux = 32'h0;
    endcase

    readdata_d = (read && !write) ? rd_mux : readdata_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q          <= ST_IDLE;
      stage_lo_q       <= 32'h0;
      stage_hi_q       <= 16'h0;
      enable_q         <= 1'b0;
      loaded_q         <= 1'b0;
      commit_count_q   <= 8'h0;
      flagged_mac_q    <= 48'h0;
      mac_valid_q      <= 1'b0;
      update_pending_q <= 1'b0;
      commit_pulse_q   <= 1'b0;
      readdata_q       <= 32'h0;
    end else begin
      state_q          <= state_d;
      stage_lo_q       <= stage_lo_d;
      stage_hi_q       <= stage_hi_d;
      enable_q         <= enable_d;
      loaded_q         <= loaded_d;
      commit_count_q   <= commit_count_d;
      flagged_mac_q    <= flagged_mac_d;
      mac_valid_q      <= mac_valid_d;
      update_pending_q <= update_pending_d;
      commit_pulse_q   <= commit_pulse_d;
      readdata_q       <= readdata_d;
    end
  end

  assign readdata       = readdata_q;
  assign flagged_mac    = flagged_mac_q;
  assign mac_valid      = mac_valid_q;
  assign update_pending = update_pending_q;
  assign commit_pulse   = commit_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_flag_mac_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flag_mac_loader
//  Purpose  : Self-checking bench for flag_mac_loader: a directed vector
//             table, hand-written multi-cycle sequences and randomized
//             traffic compared against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flag_mac_loader;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'h0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        frame_idle = 1'b1;
  logic [47:0] flagged_mac;
  logic        mac_valid;
  logic        update_pending;
  logic        commit_pulse;

  int n_chk  = 0;
  int n_pass = 0;

  flag_mac_loader dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .address        (address),
    .write          (write),
    .writedata      (writedata),
    .read           (read),
    .readdata       (readdata),
    .frame_idle     (frame_idle),
    .flagged_mac    (flagged_mac),
    .mac_valid      (mac_valid),
    .update_pending (update_pending),
    .commit_pulse   (commit_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: register-file view of the block.
  logic [31:0] m_lo, m_rd;
  logic [15:0] m_hi;
  logic [47:0] m_live;
  bit          m_en, m_loaded, m_pend, m_pulse;
  int          m_cnt;

  task automatic model_reset();
    m_lo = 0; m_hi = 0; m_live = 0; m_rd = 0;
    m_en = 0; m_loaded = 0; m_pend = 0; m_pulse = 0; m_cnt = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a == 2'd3) begin
      r[0]    = m_pend;
      r[1]    = m_en && m_loaded;
      r[15:8] = m_cnt[7:0];
    end else if (a == 2'd2) begin
      r[0] = m_en;
    end
`ifdef MAC_READBACK_EN
    else if (a == 2'd0) r = m_lo;
    else r = {16'h0, m_hi};
`endif
    return r;
  endfunction

  task automatic model_step(input bit wr, input bit rd, input logic [1:0] a,
                            input logic [31:0] wd, input bit fi);
    bit stg, hiw, abt, cmt;
    stg = wr && (a < 2);
    hiw = wr && (a == 2'd1);
    abt = wr && (a == 2'd2) && wd[1];
    // A pending address is committed when the frame is idle, nobody is
    // touching the staging pair and no abort arrives.
    cmt = m_pend && !abt && fi && !stg;
    if (rd && !wr) m_rd = model_read(a);
    if (cmt) begin
      m_live   = {m_hi, m_lo};
      m_loaded = 1;
      m_cnt    = (m_cnt + 1) % 256;
    end
    if (wr && a == 2'd0) m_lo = wd;
    if (hiw) m_hi = wd[15:0];
    if (wr && a == 2'd2) m_en = wd[0];
    m_pulse = cmt;
    m_pend  = hiw || (m_pend && !abt && !cmt);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input bit wr, input bit rd, input logic [1:0] a,
                       input logic [31:0] wd, input bit fi);
    write = wr; read = rd; address = a; writedata = wd; frame_idle = fi;
  endtask

  // One clock with model comparison of every output.
  task automatic cyc(input bit wr, input bit rd, input logic [1:0] a,
                     input logic [31:0] wd, input bit fi);
    drive(wr, rd, a, wd, fi);
    model_step(wr, rd, a, wd, fi);
    @(posedge clk); #1;
    chk("flagged_mac",    {16'h0, flagged_mac}, {16'h0, m_live});
    chk("update_pending", {63'h0, update_pending}, {63'h0, m_pend});
    chk("commit_pulse",   {63'h0, commit_pulse}, {63'h0, m_pulse});
    chk("mac_valid",      {63'h0, mac_valid}, {63'h0, (m_en && m_loaded)});
    chk("readdata",       {32'h0, readdata}, {32'h0, m_rd});
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    drive(0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          wr, rd;
    logic [1:0]  a;
    logic [31:0] wd;
    bit          fi;
    logic [47:0] e_mac;
    bit          e_pend, e_pulse, e_valid;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[15];
  logic [31:0] rb_lo, rb_hi;
  logic [47:0] held;

  initial begin
`ifdef MAC_READBACK_EN
    rb_lo = 32'h33445566; rb_hi = 32'h00000001;
`else
    rb_lo = 32'h0;        rb_hi = 32'h0;
`endif
    //          wr rd a  wd            fi  mac               pd pu va rd
    vecs[0]  = '{0, 1, 3, 32'h0,        1, 48'h0,            0, 0, 0, 32'h0};
    vecs[1]  = '{1, 0, 0, 32'h33445566, 1, 48'h0,            0, 0, 0, 32'h0};
    vecs[2]  = '{1, 0, 1, 32'h00001122, 1, 48'h0,            1, 0, 0, 32'h0};
    vecs[3]  = '{0, 0, 0, 32'h0,        1, 48'h112233445566, 0, 1, 0, 32'h0};
    vecs[4]  = '{0, 1, 3, 32'h0,        1, 48'h112233445566, 0, 0, 0, 32'h100};
    vecs[5]  = '{1, 0, 2, 32'h1,        1, 48'h112233445566, 0, 0, 1, 32'h100};
    vecs[6]  = '{0, 1, 2, 32'h0,        1, 48'h112233445566, 0, 0, 1, 32'h1};
    vecs[7]  = '{0, 1, 3, 32'h0,        1, 48'h112233445566, 0, 0, 1, 32'h102};
    vecs[8]  = '{1, 0, 1, 32'hFFFF0001, 0, 48'h112233445566, 1, 0, 1, 32'h102};
    vecs[9]  = '{0, 0, 0, 32'h0,        0, 48'h112233445566, 1, 0, 1, 32'h102};
    vecs[10] = '{1, 0, 2, 32'h3,        1, 48'h112233445566, 0, 0, 1, 32'h102};
    vecs[11] = '{0, 0, 0, 32'h0,        1, 48'h112233445566, 0, 0, 1, 32'h102};
    vecs[12] = '{0, 1, 0, 32'h0,        1, 48'h112233445566, 0, 0, 1, rb_lo};
    vecs[13] = '{0, 1, 1, 32'h0,        1, 48'h112233445566, 0, 0, 1, rb_hi};
    vecs[14] = '{0, 1, 3, 32'h0,        1, 48'h112233445566, 0, 0, 1, 32'h102};

    do_reset();
    #1;
    chk("rst_flagged_mac", {16'h0, flagged_mac}, 64'h0);
    chk("rst_pulse",       {63'h0, commit_pulse}, 64'h0);

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].wd, vecs[i].fi);
      model_step(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].wd, vecs[i].fi);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_mac", i),   {16'h0, flagged_mac}, {16'h0, vecs[i].e_mac});
      chk($sformatf("vec%0d_pend", i),  {63'h0, update_pending}, {63'h0, vecs[i].e_pend});
      chk($sformatf("vec%0d_pulse", i), {63'h0, commit_pulse}, {63'h0, vecs[i].e_pulse});
      chk($sformatf("vec%0d_valid", i), {63'h0, mac_valid}, {63'h0, vecs[i].e_valid});
      chk($sformatf("vec%0d_rd", i),    {32'h0, readdata}, {32'h0, vecs[i].e_rd});
    end

    // Frame busy for 20 cycles: address stays pending, live value untouched.
    held = flagged_mac;
    cyc(1, 0, 1, 32'h0000BEEF, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("busy_pending", {63'h0, update_pending}, 64'h1);
      chk("busy_mac_held", {16'h0, flagged_mac}, {16'h0, held});
    end
    cyc(0, 0, 0, 0, 1);
    chk("busy_commit", {16'h0, flagged_mac}, 64'hBEEF33445566);

    // LO write in the cycle frame_idle rises defers the commit one edge.
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 1, 32'h00000042, 0);
    cyc(1, 0, 0, 32'hAABBCCDD, 1);
    chk("defer_no_pulse", {63'h0, commit_pulse}, 64'h0);
    cyc(0, 0, 0, 0, 1);
    chk("defer_commit", {16'h0, flagged_mac}, 64'h0042AABBCCDD);

    // Reset while ARMED clears everything at once, no pulse afterwards.
    cyc(1, 0, 1, 32'h00001234, 0);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_pending", {63'h0, update_pending}, 64'h0);
    chk("arst_mac", {16'h0, flagged_mac}, 64'h0);
    chk("arst_valid", {63'h0, mac_valid}, 64'h0);
    chk("arst_rd", {32'h0, readdata}, 64'h0);
    drive(0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("arst_no_pulse", {63'h0, commit_pulse}, 64'h0);
    n_rst = 1'b1;
    model_reset();

    // 256 commits wrap the counter.
    for (int i = 0; i < 256; i++) begin
      cyc(1, 0, 1, i, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      if (i == 0) begin
        cyc(1, 0, 2, 32'h1, 1);
        chk("enable_valid", {63'h0, mac_valid}, 64'h1);
      end
    end
    cyc(0, 1, 3, 0, 1);
    chk("wrap_count", {56'h0, readdata[15:8]}, 64'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4),
          2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 9) < 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
